// File: rtl/mul_div_unit.sv
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative RV32M multiply/divide unit (32-step shift-add / restoring)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [4:0]  rd_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0] c_all_ones = 32'hFFFF_FFFF;
   localparam logic [31:0] c_int_min  = 32'h8000_0000;

   state_t      r_state;
   logic [4:0]  r_count;
   logic [2:0]  r_funct3;
   logic [63:0] r_prod;
   logic [31:0] r_b_mag;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_result;
   logic [4:0]  r_rd_out;

   // Operand decode at accept
   logic        w_a_signed;
   logic        w_b_signed;
   logic        w_a_neg;
   logic        w_b_neg;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic        w_div_zero;
   logic        w_div_ovf;
   logic [31:0] w_fast_result;

   assign w_a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
   assign w_b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
   assign w_a_neg    = w_a_signed & rs1_data[31];
   assign w_b_neg    = w_b_signed & rs2_data[31];
   assign w_a_mag    = w_a_neg ? -rs1_data : rs1_data;
   assign w_b_mag    = w_b_neg ? -rs2_data : rs2_data;
   assign w_div_zero = funct3[2] & (rs2_data == 32'd0);
   assign w_div_ovf  = funct3[2] & ~funct3[0] & (rs1_data == c_int_min) & (rs2_data == c_all_ones);

   always_comb begin
      w_fast_result = funct3[1] ? rs1_data : c_all_ones;
      if (!w_div_zero)
         w_fast_result = funct3[1] ? 32'd0 : c_int_min;
   end

   // One iteration of the datapath; r_prod is {hi, lo} for multiply and {rem, quot} for divide
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   logic [32:0] w_div_shift;
   logic [32:0] w_div_diff;
   logic [63:0] w_div_next;

   assign w_mul_sum   = {1'b0, r_prod[63:32]} + {1'b0, r_b_mag};
   assign w_mul_next  = r_prod[0] ? {w_mul_sum, r_prod[31:1]} : {1'b0, r_prod[63:1]};
   assign w_div_shift = {r_prod[63:32], r_prod[31]};
   assign w_div_diff  = w_div_shift - {1'b0, r_b_mag};
   assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_prod[30:0], 1'b0}
                                       : {w_div_diff[31:0],  r_prod[30:0], 1'b1};

   // Final sign correction applied on the last iteration's value
   logic [63:0] w_prod_signed;
   logic [31:0] w_quot;
   logic [31:0] w_rem;
   logic [31:0] w_final;

   assign w_prod_signed = r_neg_q ? -w_mul_next : w_mul_next;
   assign w_quot        = r_neg_q ? -w_div_next[31:0] : w_div_next[31:0];
   assign w_rem         = r_neg_r ? -w_div_next[63:32] : w_div_next[63:32];

   always_comb begin
      w_final = w_prod_signed[63:32];
      if (r_funct3[2])
         w_final = r_funct3[1] ? w_rem : w_quot;
      else if (r_funct3[1:0] == 2'b00)
         w_final = w_prod_signed[31:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_count  <= 5'd0;
         r_funct3 <= 3'd0;
         r_prod   <= 64'd0;
         r_b_mag  <= 32'd0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= 32'd0;
         r_rd_out <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_funct3 <= funct3;
                  r_prod   <= {32'd0, w_a_mag};
                  r_b_mag  <= w_b_mag;
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_count  <= 5'd0;
                  r_rd_out <= rd_in;
                  if (w_div_zero || w_div_ovf) begin
                     r_result <= w_fast_result;
                     r_done   <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_busy  <= 1'b1;
                     r_state <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_prod  <= r_funct3[2] ? w_div_next : w_mul_next;
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_result <= w_final;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy   = r_busy;
   assign done   = r_done;
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module   : tb_mul_div_unit
// Brief    : Self-checking bench for mul_div_unit (vector table + random model)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [4:0]  rd_in;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_vec  = 0;
   int n_fail = 0;

   mul_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .rd_out   (rd_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Architectural reference computed with native integer arithmetic
   function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint    sa, sb, p;
      int        ia, ib;
      logic [63:0] pu;
      sa = (f3 == 3'b011) ? longint'({32'd0, a}) : longint'($signed(a));
      sb = (f3[1]) ? longint'({32'd0, b}) : longint'($signed(b));
      ia = $signed(a);
      ib = $signed(b);
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b011: begin
            p  = sa * sb;
            pu = p;
            return (f3 == 3'b000) ? pu[31:0] : pu[63:32];
         end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return ia / ib;
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return ia % ib;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Issues one op from IDLE; returns edges from accept to done and busy-cycle count
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int lat, output int busy_cnt);
      @(negedge clk);
      funct3 = f3; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      rs1_data = $urandom; rs2_data = $urandom; rd_in = 5'($urandom);
      lat = 0;
      busy_cnt = 0;
      while (!done) begin
         if (busy) busy_cnt++;
         if (lat > 100) begin
            n_vec++; n_fail++;
            $display("FAIL timeout: no done after %0d cycles, expected within 33", lat);
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   vec_t vecs[$];

   initial begin
      int lat, bc;
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [4:0]  rd;
      logic [31:0] exp1;

      reset = 1'b1; start = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0; rd_in = 5'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd_out", {27'd0, rd_out}, 32'd0);
      reset = 1'b0;

      vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 32});
      vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 32});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 32});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 32});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 32});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 32});
      vecs.push_back('{3'b101, 32'd100,       32'd7,         5'd11, 32'd14,        32});
      vecs.push_back('{3'b111, 32'd100,       32'd7,         5'd12, 32'd2,         32});
      vecs.push_back('{3'b101, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 0});
      vecs.push_back('{3'b110, 32'h1234,      32'd0,         5'd14, 32'h1234,      0});
      vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0});
      vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0});

      foreach (vecs[i]) begin
         run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, bc);
         check($sformatf("vec%0d_result", i), result, vecs[i].exp_res);
         check($sformatf("vec%0d_rd_out", i), {27'd0, rd_out}, {27'd0, vecs[i].rd});
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].exp_lat);
      end

      // Reset in the middle of CALC discards the operation
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 32'd123; rs2_data = 32'd456; rd_in = 5'd3; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check("midreset_busy", {31'd0, busy}, 32'd0);
      check("midreset_done", {31'd0, done}, 32'd0);
      check("midreset_result", result, 32'd0);
      run_op(3'b000, 32'd3, 32'd4, 5'd1, lat, bc);
      check("post_reset_mul", result, 32'd12);
      check("post_reset_latency", lat, 32);

      // start held high across an operation: second request waits for IDLE
      @(negedge clk);
      funct3 = 3'b011; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h1234_5678; rd_in = 5'd20; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      funct3 = 3'b111; rs1_data = 32'd1000; rs2_data = 32'd33; rd_in = 5'd21;
      lat = 0;
      while (!done && lat <= 100) begin
         @(negedge clk);
         lat++;
      end
      check("held_first_latency", lat, 32);
      check("held_first_result", result, model(3'b011, 32'hDEAD_BEEF, 32'h1234_5678));
      check("held_first_rd", {27'd0, rd_out}, 32'd20);
      @(negedge clk);
      check("held_idle_busy", {31'd0, busy}, 32'd0);
      check("held_idle_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      check("held_second_accepted", {31'd0, busy}, 32'd1);
      start = 1'b0;
      lat = 0;
      while (!done && lat <= 100) begin
         @(negedge clk);
         lat++;
      end
      check("held_second_result", result, 32'd10);
      check("held_second_rd", {27'd0, rd_out}, 32'd21);

      // Randomized ops against the reference model
      for (int k = 0; k < 40; k++) begin
         f3 = 3'($urandom);
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         rd = 5'($urandom);
         exp1 = model(f3, a, b);
         run_op(f3, a, b, rd, lat, bc);
         check($sformatf("rand%0d_f3_%0d_%h_%h", k, f3, a, b), result, exp1);
         check($sformatf("rand%0d_rd_out", k), {27'd0, rd_out}, {27'd0, rd});
         check($sformatf("rand%0d_latency", k), lat,
               (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide execution unit that sits directly downstream of the register file read ports and upstream of its write port. It takes the two source operands and destination index of an M-extension instruction and runs a 32-step shift-add multiply or restoring divide. It then presents a 32-bit result with a one-cycle `done` pulse, which the writeback path routes to `rd_din`/`write_enable`. The CPU holds the PC while `busy` is high.

## Interface
No parameters (XLEN fixed at 32).
- `clk`  input  1  system clock, all state updates on rising edge
- `reset`  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `start`  input  1  request; sampled only in IDLE
- `funct3`  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `rs1_data`  input  32  operand A (register file rs1 output)
- `rs2_data`  input  32  operand B (register file rs2 output)
- `rd_in`  input  5  destination register index
- `busy`  output  1  high while state is CALC
- `done`  output  1  high for exactly one cycle (state DONE); result valid
- `result`  output  32  operation result; held until next accepted start
- `rd_out`  output  5  `rd_in` latched at accept; held like `result`

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=1 latches `funct3`, `rd_in`, operand magnitudes, and result-sign flags.
  - Next state is CALC, with step counter = 0.
  - Fast paths go directly to DONE, with the result latched at the accept edge:
    - DIV/DIVU/REM/REMU with B=0: quotient = 0xFFFFFFFF, remainder = A.
    - DIV/REM with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- CALC: one iteration per cycle; counter increments 0..31; after the iteration with counter=31, go to DONE.
  - Multiply: 64-bit unsigned shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle, on magnitudes.
- DONE:
  - `done`=1; final sign correction is already applied to `result`.
  - Next state is IDLE unconditionally; `start` in DONE is ignored.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Sign rules:
  - Product is negated (64-bit two's complement) if the operand signs differ.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- `start` while in CALC or DONE is ignored; no queuing.
- Operands are sampled only at the accept edge; later changes on `rs1_data`/`rs2_data` have no effect.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0.
- Reset has priority over everything, including mid-CALC. The in-flight operation is discarded, and no `done` is produced.
- Normal latency:
  - Accept edge E0.
  - `busy` high in the cycles after E0..E31.
  - DONE entered at E32; `done` high in the cycle after E32.
  - Back to IDLE at E33.
  - `start` can be accepted again at E34 at the earliest.
- Fast-path latency: DONE entered at E0; `done` high in the cycle after E0; `busy` never asserts.
- `result`/`rd_out` change only at the edge entering DONE, or at reset.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5 -> `done` exactly 33 cycles after accept; `result`=0xFFFFFFEB; `rd_out`=5; `busy` high for 32 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV −7/2 -> 0xFFFFFFFD. REM −7%2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 0x1234/0 -> `done` in the cycle after accept; `result`=0xFFFFFFFF; `busy` stays 0. REM 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, `done` also in the cycle after accept.
- `reset` pulsed at CALC iteration 10 -> next cycle `busy`=0, `done`=0, `result`=0. A following MUL 3×4 completes normally with 12 after 33 cycles.
- Second `start` (different operands) held high throughout an operation -> ignored during CALC and DONE; first result correct; the second is accepted at the first IDLE cycle.
